// File: rtl/xgmii_tx_arbiter.sv
// rtl/xgmii_tx_arbiter.sv - round-robin XGMII transmit scheduler sharing one port between three frame sources
module xgmii_tx_arbiter #(
  parameter int IFG_WORDS = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [2:0]   port_en,
  input  logic [2:0]   req_valid,
  input  logic [191:0] req_data,
  input  logic [2:0]   req_last,
  input  logic [8:0]   req_bytes,
  output logic [2:0]   req_ready,
  output logic [63:0]  xgmii_txd,
  output logic [7:0]   xgmii_txc,
  output logic [1:0]   grant,
  output logic         busy,
  output logic [31:0]  frames_sent,
  output logic [15:0]  underrun_cnt
);

  localparam int NREQ = 3;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [3:0]  IFG_LOAD = 4'(IFG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_TERM = 3'd2,
    S_ERR  = 3'd3,
    S_IFG  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [63:0]   txd_q, txd_d;
  logic [7:0]    txc_q, txc_d;
  logic [3:0]    ifg_q, ifg_d;
  logic [31:0]   frames_q, frames_d;
  logic [15:0]   urun_q, urun_d;

  logic [NREQ-1:0] elig;
  logic [1:0]      nxt1_idx, nxt2_idx, pick_idx;
  logic            pick_vld;

  logic            sel_valid, sel_last;
  logic [63:0]     sel_data;
  logic [2:0]      sel_bytes;
  logic [3:0]      last_n;
  logic [63:0]     part_txd;
  logic [7:0]      part_txc;

  // Mux the currently granted requester's bus onto a single set of signals
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_bytes = '0;
    case (grant_q)
      2'd0: begin
        sel_valid = req_valid[0];
        sel_last  = req_last[0];
        sel_data  = req_data[63:0];
        sel_bytes = req_bytes[2:0];
      end
      2'd1: begin
        sel_valid = req_valid[1];
        sel_last  = req_last[1];
        sel_data  = req_data[127:64];
        sel_bytes = req_bytes[5:3];
      end
      default: begin
        sel_valid = req_valid[2];
        sel_last  = req_last[2];
        sel_data  = req_data[191:128];
        sel_bytes = req_bytes[8:6];
      end
    endcase
  end

  // Round-robin pick: search grant+1, grant+2, then grant itself
  always_comb begin
    elig     = req_valid & port_en;
    nxt1_idx = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
    nxt2_idx = (nxt1_idx == 2'd2) ? 2'd0 : nxt1_idx + 2'd1;
    pick_vld = 1'b1;
    pick_idx = grant_q;
    if (elig[nxt1_idx]) begin
      pick_idx = nxt1_idx;
    end else if (elig[nxt2_idx]) begin
      pick_idx = nxt2_idx;
    end else if (elig[grant_q]) begin
      pick_idx = grant_q;
    end else begin
      pick_vld = 1'b0;
    end
  end

  // Build the partial last word: data lanes, then terminate, then idle fill
  always_comb begin
    last_n   = (sel_bytes == 3'd0) ? 4'd8 : {1'b0, sel_bytes};
    part_txd = '0;
    part_txc = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < last_n) begin
        part_txd[8*k +: 8] = sel_data[8*k +: 8];
        part_txc[k]        = 1'b0;
      end else if (4'(k) == last_n) begin
        part_txd[8*k +: 8] = 8'hFD;
        part_txc[k]        = 1'b1;
      end else begin
        part_txd[8*k +: 8] = 8'h07;
        part_txc[k]        = 1'b1;
      end
    end
  end

  // FSM state register; reset aborts any frame on the wire immediately
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pick_vld) state_d = S_DATA;
      S_DATA: begin
        if (!sel_valid) begin
          state_d = S_ERR;
        end else if (sel_last) begin
          state_d = (last_n == 4'd8) ? S_TERM : S_IFG;
        end
      end
      S_TERM:  state_d = S_IFG;
      S_ERR:   state_d = S_IFG;
      S_IFG:   if (ifg_q == 4'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready only for the granted requester while streaming data
  always_comb begin
    req_ready = (state_q == S_DATA) ? (3'b001 << grant_q) : 3'b000;
    busy      = (state_q != S_IDLE);
  end

  // Next value of the registered XGMII word, grant, gap counter and statistics
  always_comb begin
    txd_d    = txd_q;
    txc_d    = txc_q;
    grant_d  = grant_q;
    ifg_d    = ifg_q;
    frames_d = frames_q;
    urun_d   = urun_q;
    case (state_q)
      S_IDLE: begin
        txd_d = IDLE_W;
        txc_d = 8'hFF;
        if (pick_vld) begin
          grant_d = pick_idx;
          txd_d   = START_W;
          txc_d   = 8'h01;
        end
      end
      S_DATA: begin
        if (!sel_valid) begin
          txd_d = ERR_W;
          txc_d = 8'hFF;
        end else if (sel_last && (last_n != 4'd8)) begin
          txd_d    = part_txd;
          txc_d    = part_txc;
          frames_d = frames_q + 32'd1;
          ifg_d    = IFG_LOAD;
        end else begin
          txd_d = sel_data;
          txc_d = 8'h00;
        end
      end
      S_TERM: begin
        txd_d    = TERM_W;
        txc_d    = 8'hFF;
        frames_d = frames_q + 32'd1;
        ifg_d    = IFG_LOAD;
      end
      S_ERR: begin
        txd_d  = TERM_W;
        txc_d  = 8'hFF;
        urun_d = (urun_q == 16'hFFFF) ? urun_q : urun_q + 16'd1;
        ifg_d  = IFG_LOAD;
      end
      S_IFG: begin
        txd_d = IDLE_W;
        txc_d = 8'hFF;
        ifg_d = ifg_q - 4'd1;
      end
      default: begin
        txd_d = IDLE_W;
        txc_d = 8'hFF;
      end
    endcase
  end

  // Datapath registers; grant resets to 2 so requester 0 is first in rotation
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      grant_q  <= 2'd2;
      txd_q    <= IDLE_W;
      txc_q    <= 8'hFF;
      ifg_q    <= 4'd0;
      frames_q <= 32'd0;
      urun_q   <= 16'd0;
    end else begin
      grant_q  <= grant_d;
      txd_q    <= txd_d;
      txc_q    <= txc_d;
      ifg_q    <= ifg_d;
      frames_q <= frames_d;
      urun_q   <= urun_d;
    end
  end

  assign xgmii_txd    = txd_q;
  assign xgmii_txc    = txc_q;
  assign grant        = grant_q;
  assign frames_sent  = frames_q;
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// tb/tb_xgmii_tx_arbiter.sv - randomized bench for xgmii_tx_arbiter against a frame-level wire model
module tb_xgmii_tx_arbiter;

  localparam int IFG  = 2;
  localparam int FR   = 60;
  localparam int MW   = 6;
  localparam int NCMP = 150;

  localparam logic [71:0] IDLE72  = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] START72 = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] TERM72  = {8'hFF, 64'h07070707070707FD};
  localparam logic [71:0] ERR72   = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic [2:0]   port_en;
  logic [2:0]   req_valid;
  logic [191:0] req_data;
  logic [2:0]   req_last;
  logic [8:0]   req_bytes;
  logic [2:0]   req_ready;
  logic [63:0]  xgmii_txd;
  logic [7:0]   xgmii_txc;
  logic [1:0]   grant;
  logic         busy;
  logic [31:0]  frames_sent;
  logic [15:0]  underrun_cnt;

  always #5 sys_clk = ~sys_clk;

  xgmii_tx_arbiter #(.IFG_WORDS(IFG)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .port_en      (port_en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_bytes    (req_bytes),
    .req_ready    (req_ready),
    .xgmii_txd    (xgmii_txd),
    .xgmii_txc    (xgmii_txc),
    .grant        (grant),
    .busy         (busy),
    .frames_sent  (frames_sent),
    .underrun_cnt (underrun_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-requester frame lists
  logic [63:0] fdata  [3][FR][MW];
  int          flen   [3][FR];
  logic [2:0]  fbytes [3][FR];
  int          fabort [3][FR];
  int          fi [3];
  int          wi [3];
  logic [2:0]  acc_prev, drop_prev;

  // Expected wire stream
  logic [71:0] exp_w [$];
  int          exp_fs[$];
  int          exp_uc[$];
  int          exp_g [$];
  bit          exp_b [$];

  task automatic gen_frames();
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < FR; f++) begin
        flen[r][f]   = int'($urandom_range(1, MW));
        fbytes[r][f] = 3'($urandom_range(0, 7));
        fabort[r][f] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, flen[r][f] - 1)) : -1;
        for (int w = 0; w < MW; w++) begin
          fdata[r][f][w] = {8'(r + 1), 24'($urandom), 32'($urandom)};
        end
      end
    end
  endtask

  task automatic push(input logic [71:0] w, input int fs, input int uc, input int g, input bit b);
    exp_w.push_back(w);
    exp_fs.push_back(fs);
    exp_uc.push_back(uc);
    exp_g.push_back(g);
    exp_b.push_back(b);
  endtask

  // Every enabled requester always has a frame waiting, so the wire is a
  // strict rotation over enabled requesters, frame after frame.
  task automatic build_model(input logic [2:0] mask);
    int g, fs, uc, r, f, n, c;
    int nf [3];
    bit done;
    logic [63:0] d, pd;
    logic [7:0]  pc;
    exp_w.delete(); exp_fs.delete(); exp_uc.delete(); exp_g.delete(); exp_b.delete();
    g = 2; fs = 0; uc = 0; done = 0;
    nf[0] = 0; nf[1] = 0; nf[2] = 0;
    while (!done) begin
      r = -1;
      for (int s = 1; s <= 3; s++) begin
        c = (g + s) % 3;
        if (r < 0 && mask[c]) r = c;
      end
      if (nf[r] >= FR) begin
        done = 1;
      end else begin
        g = r;
        f = nf[r];
        nf[r]++;
        push(START72, fs, uc, g, 1);
        if (fabort[r][f] >= 0) begin
          for (int w = 0; w < fabort[r][f]; w++) push({8'h00, fdata[r][f][w]}, fs, uc, g, 1);
          push(ERR72, fs, uc, g, 1);
          uc++;
          push(TERM72, fs, uc, g, 1);
        end else begin
          for (int w = 0; w < flen[r][f] - 1; w++) push({8'h00, fdata[r][f][w]}, fs, uc, g, 1);
          d = fdata[r][f][flen[r][f] - 1];
          n = (fbytes[r][f] == 3'd0) ? 8 : int'(fbytes[r][f]);
          if (n == 8) begin
            push({8'h00, d}, fs, uc, g, 1);
            fs++;
            push(TERM72, fs, uc, g, 1);
          end else begin
            pd = '0;
            pc = '0;
            for (int k = 0; k < 8; k++) begin
              if (k < n) begin
                pd[8*k +: 8] = d[8*k +: 8];
              end else begin
                pd[8*k +: 8] = (k == n) ? 8'hFD : 8'h07;
                pc[k] = 1'b1;
              end
            end
            fs++;
            push({pc, pd}, fs, uc, g, 1);
          end
        end
        for (int i = 1; i <= IFG; i++) push(IDLE72, fs, uc, g, i < IFG);
      end
    end
  endtask

  // Called just after a falling edge: retire what the last rising edge
  // accepted, then present each requester's next word.
  task automatic drive_cycle();
    for (int i = 0; i < 3; i++) begin
      if (fi[i] < FR) begin
        if (acc_prev[i]) begin
          if (wi[i] == flen[i][fi[i]] - 1) begin
            fi[i]++;
            wi[i] = 0;
          end else begin
            wi[i]++;
          end
        end else if (drop_prev[i]) begin
          fi[i]++;
          wi[i] = 0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (fi[i] < FR) begin
        req_valid[i]         = !(req_ready[i] && (fabort[i][fi[i]] == wi[i]));
        req_data[64*i +: 64] = fdata[i][fi[i]][wi[i]];
        req_last[i]          = (wi[i] == flen[i][fi[i]] - 1);
        req_bytes[3*i +: 3]  = fbytes[i][fi[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
      acc_prev[i]  = req_valid[i] & req_ready[i];
      drop_prev[i] = req_ready[i] & ~req_valid[i];
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_txd"},    xgmii_txd, IDLE72[63:0]);
    check_eq({tag, "_txc"},    xgmii_txc, 8'hFF);
    check_eq({tag, "_ready"},  req_ready, 3'b000);
    check_eq({tag, "_busy"},   busy, 1'b0);
  endtask

  task automatic run_phase(input logic [2:0] mask);
    bit aligned;
    int e, c;
    gen_frames();
    build_model(mask);
    port_en   = mask;
    req_valid = '0;
    req_last  = '0;
    acc_prev  = '0;
    drop_prev = '0;
    for (int i = 0; i < 3; i++) begin
      fi[i] = 0;
      wi[i] = 0;
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_reset_state("rst");
    check_eq("rst_grant",  grant, 2'd2);
    check_eq("rst_frames", frames_sent, 32'd0);
    check_eq("rst_urun",   underrun_cnt, 16'd0);
    sys_rst = 1'b1;
    drive_cycle();
    aligned = 0;
    e = 0;
    for (c = 0; c < NCMP + 20 && e < NCMP; c++) begin
      @(negedge sys_clk);
      if (!aligned && ({xgmii_txc, xgmii_txd} == START72)) aligned = 1;
      if (aligned && e < exp_w.size()) begin
        check_eq($sformatf("word[%0d] mask=%0b", e, mask), {xgmii_txc, xgmii_txd}, exp_w[e]);
        check_eq($sformatf("fs/uc/grant/busy[%0d] mask=%0b", e, mask),
                 {frames_sent, underrun_cnt, grant, busy},
                 {32'(exp_fs[e]), 16'(exp_uc[e]), 2'(exp_g[e]), exp_b[e]});
        e++;
      end
      check_eq("ready_masked", req_ready & ~mask, 3'b000);
      drive_cycle();
    end
    check_eq("words_compared", e, NCMP);

    // Asynchronous reset while a frame is streaming
    for (c = 0; c < 40 && req_ready == 3'b000; c++) begin
      @(negedge sys_clk);
      drive_cycle();
    end
    check_eq("midframe_ready_seen", (req_ready != 3'b000), 1'b1);
    #2;
    sys_rst = 1'b0;
    #1;
    check_reset_state("arst");
    check_eq("arst_grant", grant, 2'd2);
  endtask

  initial begin
    sys_rst   = 1'b0;
    port_en   = 3'b000;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    req_bytes = '0;
    acc_prev  = '0;
    drop_prev = '0;
    run_phase(3'b111);
    run_phase(3'b101);
    run_phase(3'b010);
    run_phase(3'b111);
    for (int p = 0; p < 4; p++) begin
      run_phase(3'($urandom_range(1, 7)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_arbiter.md
# xgmii_tx_arbiter

Egress scheduler for one 10G port of the L2 switch. It shares a single XGMII transmit interface between three ingress frame sources, one frame at a time, using round-robin arbitration. It adds the XGMII framing: start/preamble word, terminate character, idle insertion and a minimum inter-frame gap. One instance sits in front of each `xgmii_N_txd`/`xgmii_N_txc` pair, fed by the forwarding queues of the other three ports.

## Interface

Parameters:
- `IFG_WORDS`, default 2: idle words emitted after the word carrying the terminate character. Legal range 1..15.
- `NREQ`, fixed 3: number of requesters. Not overridable.

Ports:
- `sys_clk`, in, 1: 156.25 MHz XGMII clock. All logic is on its rising edge.
- `sys_rst`, in, 1: asynchronous, active-low reset.
- `port_en`, in, 3: per-requester enable. A disabled requester is never granted a new frame.
- `req_valid`, in, 3: requester i has a word on its data bus.
- `req_data`, in, 192: requester i's data word is `[64*i+63:64*i]`. Byte k of the word goes to XGMII lane k, `[8k+7:8k]`.
- `req_last`, in, 3: the current word is the frame's last word.
- `req_bytes`, in, 9: requester i's field is `[3*i+2:3*i]`. It gives the number of valid bytes in the last word (1..7); 0 means 8. Ignored unless `req_last` is high.
- `req_ready`, out, 3: word accepted on this edge when valid && ready.
- `xgmii_txd`, out, 64: XGMII transmit data, registered.
- `xgmii_txc`, out, 8: XGMII transmit control, registered.
- `grant`, out, 2: index of the current or last granted requester.
- `busy`, out, 1: high in every state except IDLE.
- `frames_sent`, out, 32: count of frames that completed without underrun. Wraps.
- `underrun_cnt`, out, 16: count of aborted frames. Saturates at 0xFFFF.

## Operation

- **Idle word:** txd = 0x0707070707070707, txc = 0xFF.
- **States:** IDLE, DATA, TERM, ERR, IFG.
- **IDLE:**
  - Outputs the idle word.
  - If any `req_valid[i] && port_en[i]`, it picks the first such i in the order grant+1, grant+2, grant (mod 3).
  - On that edge it latches `grant` and registers the start word: txd = 0xD5555555555555FB, txc = 0x01.
  - Next state is DATA.
- **DATA:**
  - `req_ready[grant]` = 1; all other ready bits are 0. Ready is combinational from state and grant.
  - On valid && ready the word is registered with txc = 0x00.
  - If `req_last` with bytes n = 1..7: lanes 0..n-1 carry data, lane n = 0xFD, lanes above n = 0x07. txc has bits n..7 set. Go to IFG and increment `frames_sent`.
  - If `req_last` with n = 8: go to TERM.
  - If `req_valid[grant]` = 0 in DATA (underrun): register an error word (txd = 0xFEFEFEFEFEFEFEFE, txc = 0xFF) and go to ERR. No data is accepted.
- **TERM:** register txd = 0x07070707070707FD, txc = 0xFF. Increment `frames_sent` and go to IFG.
- **ERR:** register the TERM word, increment `underrun_cnt`, go to IFG. The rest of the aborted frame stays in the requester; flushing it is the requester's job, up to its next `req_last`.
- **IFG:** emit the idle word for `IFG_WORDS` cycles, using a 4-bit down-counter, then go to IDLE.
- **`port_en` changes:** they take effect only at arbitration. Clearing a bit mid-frame does not abort that frame.
- **Reset:** asserting `sys_rst` mid-frame forces IDLE immediately, truncating the frame on the wire.

## Timing

- **Reset values:** state IDLE, txd = 0x0707070707070707, txc = 0xFF, req_ready = 0, grant = 2 (so requester 0 wins first), busy = 0, frames_sent = 0, underrun_cnt = 0.
- **Arbitration latency:** valid sampled at edge E0 puts the start word on the output after E0. `req_ready` rises after E0. The first data word is accepted at E1 and appears on txd after E1.
- **Throughput:** one word per cycle in DATA. Requesters must hold `req_valid` continuously from the first word to the last.
- **Minimum frame-to-frame spacing on the wire:**
  - Full last word (n = 8): 1 TERM word + `IFG_WORDS` idle words.
  - Partial last word: `IFG_WORDS` idle words.
- **Back-to-back requests:** the earliest new arbitration is in the IDLE cycle that immediately follows IFG. Back-to-back requests rotate strictly.
- **Same-cycle requests:** when requests arrive in the same cycle, the rotation order decides.

## Test plan

- **Single frame, partial last word:** reset, then requester 0 sends 8 words with the last word at bytes = 4.
  - Output: start word, 7 data words with txc 0x00, last word with txc 0xF0 and lane 4 = 0xFD, then 2 idle words.
  - frames_sent = 1.
- **Full last word:** requester 1 sends 2 words with the last word at bytes = 0.
  - Output: a separate 0x07070707070707FD/0xFF word after the data, then the IFG.
- **Round-robin:** all three requesters hold valid after reset.
  - Grants run 0, 1, 2, 0.
  - Each gap is exactly IFG_WORDS idle words (or TERM + IFG).
- **port_en masking:** port_en = 0b101 with all requesters valid.
  - Requester 1 is never granted; req_ready[1] stays 0.
- **Underrun:** requester 2 drops valid after 3 words.
  - Output: error word 0xFE×8/0xFF, then the TERM word, then idle.
  - underrun_cnt = 1; frames_sent is unchanged.
- **Reset mid-frame:** assert sys_rst during DATA.
  - Outputs return to the idle word/0xFF and req_ready to 0 without waiting for a clock edge.
  - Grant after release is requester 0.
